uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with a built-in baud timer and a transmit FIFO.
//  It takes words over a valid/ready handshake, buffers them, and serialises each one LSB-first.
//  Frame format is configurable: data bits, parity none/even/odd, and 1 or 2 stop bits.
//  Sits between the message/packet logic and the Bluetooth module's RX pin; the host never waits on bit timing.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200 baud); legal range >=2
//  DATA_BITS     8    data bits per frame; legal range 5..9
//  PARITY_MODE   0    0 = none, 1 = even, 2 = odd
//  STOP_BITS     1    stop bits per frame; 1 or 2
//  FIFO_DEPTH    16   FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1                     system clock
//  rst_in      in   1                     synchronous active-high reset
//  tx_data     in   DATA_BITS             word to send; sampled only when tx_valid && tx_ready
//  tx_valid    in   1                     producer has a word
//  tx_ready    out  1                     FIFO not full; combinational from the registered count
//  tx          out  1                     serial line, registered, idles high
//  busy        out  1                     high while the FSM is not IDLE or FIFO count != 0
//  frame_done  out  1                     one-cycle pulse in the last cycle of the final stop bit
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered, excluding the word being shifted
// BEHAVIOUR
//  Reset (any time, including mid-frame); all values apply from the next edge:
//   - tx=1, frame_done=0, busy=0, fifo_count=0, tx_ready=1
//   - FSM in IDLE, FIFO emptied, the partial frame is abandoned
//  FIFO:
//   - push on tx_valid && tx_ready; pop only by the FSM
//   - push and pop on the same edge leave the count unchanged
//   - while full, tx_ready=0 and tx_data is ignored; pointers wrap modulo FIFO_DEPTH
//  Bit timer:
//   - loads CLKS_PER_BIT-1 on each bit start and counts down to 0
//   - every bit holds tx for exactly CLKS_PER_BIT cycles
//   - frame length in cycles = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS), with P=0 if PARITY_MODE==0, else 1
//  FSM states: IDLE, START, DATA, PARITY, STOP
//   - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START, drive tx=0.
//   - START -> DATA when the timer expires. DATA shifts LSB first and sends DATA_BITS bits.
//   - DATA -> PARITY when PARITY_MODE!=0, else DATA -> STOP.
//   - PARITY bit value: even = ^word, odd = ~^word.
//   - STOP: tx=1 for STOP_BITS bit periods; frame_done=1 in the final cycle.
//   - STOP exit, FIFO non-empty: pop on the same edge and go directly to START (no idle gap).
//   - STOP exit, FIFO empty: go to IDLE.
//  Latency: a word accepted on edge E into an empty FIFO with the FSM in IDLE pops at edge E+1; tx falls at edge E+2.
//  The word is latched at pop; later changes on tx_data do not affect the frame in flight.
//  DATA_BITS=9 with parity gives 12-bit frames; no other width rule applies.
// TESTING (bench default CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//  1. Reset: assert rst_in mid-DATA for 1 cycle
//     -> next edge tx=1, busy=0, fifo_count=0, tx_ready=1; no frame_done pulse.
//  2. 8N1, push 0xA5
//     -> tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total).
//     -> tx falls 2 edges after the accepting edge; frame_done fires at cycle 40.
//  3. 8E1: 0x07 -> parity bit 1; 0x00 -> parity bit 0. 8O1: 0x07 -> parity bit 0.
//     -> each frame is 44 cycles.
//  4. Back-to-back: push 0x11, 0x22, 0x33 on consecutive cycles
//     -> three contiguous frames with no idle-high gap; frame_done pulses 40 cycles apart; busy falls after the third.
//  5. Full: hold tx_valid for 6 words
//     -> words 1..5 accepted (word 1 popped at once), fifo_count=4, tx_ready=0.
//     -> word 6 accepted on the cycle after the first frame_done; all 6 words transmitted in order.
//  6. DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2, push 7'h41
//     -> 11-bit frame of 44 cycles: data 1,0,0,0,0,0,1, parity 0, then 8 cycles high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with its own baud timer and a transmit FIFO.
// Frame: start bit, DATA_BITS data bits (LSB first), optional parity bit, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = 4;

  localparam logic [TW-1:0]   BIT_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DATA_LAST  = CNTW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] STOP_LAST  = CNTW'(STOP_BITS - 1);
  localparam logic            HAS_PARITY = (PARITY_MODE != 0);
  localparam logic            PAR_ODD    = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNTW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bit_end;
  logic                 start_frame;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  assign tx         = tx_q;
  assign frame_done = frame_done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tx_d         = 1'b1;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;
    pop          = 1'b0;
    bit_end      = (timer_q == '0);

    if (state_q != S_IDLE) timer_d = bit_end ? BIT_LAST : timer_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = HAS_PARITY ? S_PARITY : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            frame_done_d = 1'b1;
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d     = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Latch the head word and its parity at pop so later tx_data changes cannot leak in.
    if (start_frame) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = (^head) ^ PAR_ODD;
      state_d = S_START;
      timer_d = BIT_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 8E1, 8O1 and 7E2 framing.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       vld   [4];
  logic [7:0] dat   [3];
  logic [6:0] dat7;
  logic       tx_o  [4];
  logic       rdy_o [4];
  logic       busy_o[4];
  logic       fd_o  [4];
  logic [2:0] cnt_o [4];

  int checks   = 0;
  int failures = 0;

  logic [15:0] seq5 [6];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_in(rst_in), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy_o[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]), .fifo_count(cnt_o[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst_in(rst_in), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy_o[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]), .fifo_count(cnt_o[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_in(rst_in), .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy_o[2]),
    .tx(tx_o[2]), .busy(busy_o[2]), .frame_done(fd_o[2]), .fifo_count(cnt_o[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
    .clk(clk), .rst_in(rst_in), .tx_data(dat7), .tx_valid(vld[3]), .tx_ready(rdy_o[3]),
    .tx(tx_o[3]), .busy(busy_o[3]), .frame_done(fd_o[3]), .fifo_count(cnt_o[3]));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] w);
    @(posedge clk); #1;
    vld[idx] = 1'b1;
    if (idx == 3) dat7 = w[6:0];
    else          dat[idx] = w;
    @(posedge clk); #1;
    vld[idx] = 1'b0;
  endtask

  // Returns the number of falling clock edges until tx is seen low (bounded).
  task automatic wait_fall(input int idx, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_o[idx] !== 1'b0 && n < 200);
  endtask

  // seq is written in time order, first bit leftmost; every bit must hold CPB cycles.
  task automatic rx_frame(input int idx, input string tag, input logic [15:0] seq,
                          input int nbits, input bit first_done);
    int   bad;
    int   fd_cnt;
    logic fd_last;
    bad     = 0;
    fd_cnt  = 0;
    fd_last = 1'b0;
    for (int c = 0; c < nbits * CPB; c++) begin
      if (c > 0 || !first_done) @(negedge clk);
      if (tx_o[idx] !== seq[nbits - 1 - c / CPB]) bad++;
      if (fd_o[idx] === 1'b1) fd_cnt++;
      if (c == nbits * CPB - 1) fd_last = fd_o[idx];
    end
    check({tag, "_bits"}, bad, 0);
    check({tag, "_fd_last"}, int'(fd_last), 1);
    check({tag, "_fd_cnt"}, fd_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lows;
    int pulses;
    int busies;

    seq5[0] = 16'b0100000001;
    seq5[1] = 16'b0010000001;
    seq5[2] = 16'b0110000001;
    seq5[3] = 16'b0001000001;
    seq5[4] = 16'b0101000001;
    seq5[5] = 16'b0011000001;

    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    dat7 = 7'h00;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    check("init_tx", tx_o[0], 1);
    check("init_busy", busy_o[0], 0);
    check("init_cnt", cnt_o[0], 0);
    check("init_rdy", rdy_o[0], 1);
    check("init_fd", fd_o[0], 0);

    // 8N1 0xA5 with accept-to-start latency
    push(0, 8'hA5);
    wait_fall(0, n);
    check("a5_latency", n, 3);
    check("a5_busy", busy_o[0], 1);
    rx_frame(0, "a5", 16'b0101001011, 10, 1'b1);
    @(negedge clk);
    check("a5_idle_tx", tx_o[0], 1);
    check("a5_idle_busy", busy_o[0], 0);

    // parity variants
    push(1, 8'h07);
    wait_fall(1, n);
    check("e07_latency", n, 3);
    rx_frame(1, "e07", 16'b01110000011, 11, 1'b1);
    push(1, 8'h00);
    wait_fall(1, n);
    check("e00_start", int'(n < 200), 1);
    rx_frame(1, "e00", 16'b00000000001, 11, 1'b1);
    push(2, 8'h07);
    wait_fall(2, n);
    check("o07_start", int'(n < 200), 1);
    rx_frame(2, "o07", 16'b01110000001, 11, 1'b1);

    // 7 data bits, even parity, two stop bits
    push(3, 8'h41);
    wait_fall(3, n);
    check("e2_start", int'(n < 200), 1);
    rx_frame(3, "e2_41", 16'b01000001011, 11, 1'b1);

    // back-to-back frames
    fork
      begin
        @(posedge clk); #1;
        vld[0] = 1'b1; dat[0] = 8'h11;
        @(posedge clk); #1 dat[0] = 8'h22;
        @(posedge clk); #1 dat[0] = 8'h33;
        @(posedge clk); #1 vld[0] = 1'b0;
        dat[0] = 8'hFF;
      end
      begin
        int m;
        wait_fall(0, m);
        check("b2b_start", int'(m < 200), 1);
        rx_frame(0, "b2b_11", 16'b0100010001, 10, 1'b1);
        rx_frame(0, "b2b_22", 16'b0010001001, 10, 1'b0);
        rx_frame(0, "b2b_33", 16'b0110011001, 10, 1'b0);
      end
    join
    @(negedge clk);
    check("b2b_busy_end", busy_o[0], 0);

    // FIFO full: six words with valid held high
    fork
      begin
        int   k;
        int   guard;
        logic acc;
        logic fdn;
        bit   seen_full;
        k = 1; guard = 0; seen_full = 1'b0;
        @(posedge clk); #1;
        vld[0] = 1'b1; dat[0] = 8'(k);
        while (k <= 6 && guard < 300) begin
          @(negedge clk);
          acc = rdy_o[0];
          fdn = fd_o[0];
          if (k == 6 && !seen_full) begin
            check("full_cnt", cnt_o[0], 4);
            check("full_rdy", rdy_o[0], 0);
            seen_full = 1'b1;
          end
          @(posedge clk); #1;
          guard++;
          if (acc) begin
            if (k == 6) check("full_w6_at_fd", fdn, 1);
            k++;
            dat[0] = 8'(k);
          end
        end
        vld[0] = 1'b0;
        check("full_accepted", k, 7);
      end
      begin
        int m;
        wait_fall(0, m);
        check("full_start", int'(m < 200), 1);
        for (int w = 0; w < 6; w++)
          rx_frame(0, $sformatf("full_w%0d", w + 1), seq5[w], 10, w == 0);
      end
    join
    @(negedge clk);
    check("full_busy_end", busy_o[0], 0);

    // reset in the middle of the data bits, with a word still queued
    push(0, 8'h5A);
    push(0, 8'h3C);
    wait_fall(0, n);
    repeat (8) @(negedge clk);
    @(posedge clk); #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    check("rst_tx", tx_o[0], 1);
    check("rst_busy", busy_o[0], 0);
    check("rst_cnt", cnt_o[0], 0);
    check("rst_rdy", rdy_o[0], 1);
    check("rst_fd", fd_o[0], 0);
    lows = 0; pulses = 0; busies = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_o[0] !== 1'b1) lows++;
      if (fd_o[0] === 1'b1) pulses++;
      if (busy_o[0] === 1'b1) busies++;
    end
    check("rst_quiet_tx", lows, 0);
    check("rst_quiet_fd", pulses, 0);
    check("rst_quiet_busy", busies, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
